// File: rtl/riscv_pkg.sv
// Shared RV32 constants and memory-operation encodings.
package riscv_pkg;
    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_BYTE   = 3'd0,
        MEM_HALF   = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_BYTE_U = 3'd4,
        MEM_HALF_U = 3'd5
    } mem_op_e;
endpackage

// File: rtl/store_if.sv
// Pipeline-store request side and data-memory write side of the store unit.
interface store_if;
    import riscv_pkg::*;

    logic            st_valid;
    logic            st_ready;
    logic [XLEN-1:0] st_addr;
    logic [XLEN-1:0] st_wdata;
    mem_op_e         st_op;
    logic            mem_req;
    logic            mem_gnt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_be;
    logic            st_done;
    logic            st_fault;
    logic [XLEN-1:0] st_fault_addr;

    modport master (
        output st_valid, st_addr, st_wdata, st_op, mem_gnt,
        input  st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               st_done, st_fault, st_fault_addr
    );

    modport slave (
        input  st_valid, st_addr, st_wdata, st_op, mem_gnt,
        output st_ready, mem_req, mem_addr, mem_wdata, mem_be,
               st_done, st_fault, st_fault_addr
    );
endinterface

// File: rtl/store_unit.sv
// Aligns RV32 stores onto a word-wide memory port; >=2 cycles accept-to-done.
// One store in flight: st_ready drops while waiting for mem_gnt; faults resolve in IDLE.
module store_unit
    import riscv_pkg::*;
(
    input logic   clk,
    input logic   rst,
    store_if.slave bus
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic            fault;
    logic            gnt_fire;
    logic [1:0]      off;
    logic [XLEN-1:0] wdata_al;
    logic [3:0]      be_al;

    assign bus.st_ready = (state == IDLE);
    assign bus.mem_req  = (state == ISSUE);
    assign accept       = bus.st_valid && bus.st_ready;
    assign gnt_fire     = (state == ISSUE) && bus.mem_gnt;
    assign off          = bus.st_addr[1:0];

    // Lane replication lets memory ignore the offset; be selects the lanes.
    always_comb begin
        fault    = 1'b0;
        wdata_al = bus.st_wdata;
        be_al    = 4'b1111;
        case (bus.st_op)
            MEM_BYTE: begin
                wdata_al = {4{bus.st_wdata[7:0]}};
                be_al    = 4'b0001 << off;
            end
            MEM_HALF: begin
                wdata_al = {2{bus.st_wdata[15:0]}};
                be_al    = off[1] ? 4'b1100 : 4'b0011;
                fault    = off[0];
            end
            MEM_WORD: begin
                fault = (off != 2'b00);
            end
            default: begin
                fault = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !fault) state_nxt = ISSUE;
            ISSUE:   if (bus.mem_gnt)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory-side registers only load on legal acceptance, so a fault leaves them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr      <= '0;
            bus.mem_wdata     <= '0;
            bus.mem_be        <= '0;
            bus.st_done       <= 1'b0;
            bus.st_fault      <= 1'b0;
            bus.st_fault_addr <= '0;
        end else begin
            bus.st_done  <= gnt_fire;
            bus.st_fault <= accept && fault;
            if (accept && fault) begin
                bus.st_fault_addr <= bus.st_addr;
            end
            if (accept && !fault) begin
                bus.mem_addr  <= {bus.st_addr[XLEN-1:2], 2'b00};
                bus.mem_wdata <= wdata_al;
                bus.mem_be    <= be_al;
            end
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Table-driven store vectors checked through an expectation queue, plus reset and back-to-back sequences.
module tb_store_unit;
    import riscv_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    store_if sif();

    store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    typedef struct {
        mem_op_e     op;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        logic        fault;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
    } vec_t;

    typedef struct {
        logic        fault;
        logic [31:0] fault_addr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[11];
    logic [31:0] last_addr;
    logic [31:0] last_wdata;
    logic [3:0]  last_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (sif.st_done || sif.st_fault)) begin
            check("done_fault_exclusive", {31'd0, sif.st_done && sif.st_fault}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic do_store(input vec_t v, input string tag);
        exp_t e;
        int   n;
        int   req_cycles;
        n = 0;
        while (!sif.st_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_ready_wait"}, {31'd0, sif.st_ready}, 32'd1);
        sif.st_valid = 1'b1;
        sif.st_op    = v.op;
        sif.st_addr  = v.addr;
        sif.st_wdata = v.wdata;
        e.fault      = v.fault;
        e.fault_addr = v.addr;
        e.addr       = v.exp_addr;
        e.wdata      = v.exp_wdata;
        e.be         = v.exp_be;
        sb_q.push_back(e);
        @(posedge clk); #1;
        sif.st_addr  = $urandom;
        sif.st_wdata = $urandom;
        sif.st_op    = MEM_WORD;
        e = sb_q.pop_front();
        if (e.fault) begin
            sif.st_valid = 1'b0;
            check({tag, "_st_fault"},      {31'd0, sif.st_fault}, 32'd1);
            check({tag, "_fault_addr"},    sif.st_fault_addr, e.fault_addr);
            check({tag, "_fault_no_req"},  {31'd0, sif.mem_req}, 32'd0);
            check({tag, "_fault_ready"},   {31'd0, sif.st_ready}, 32'd1);
            check({tag, "_fault_addr_kept"},  sif.mem_addr, last_addr);
            check({tag, "_fault_wdata_kept"}, sif.mem_wdata, last_wdata);
            check({tag, "_fault_be_kept"},    {28'd0, sif.mem_be}, {28'd0, last_be});
            @(posedge clk); #1;
            check({tag, "_fault_pulse_end"}, {31'd0, sif.st_fault}, 32'd0);
            check({tag, "_fault_addr_hold"}, sif.st_fault_addr, e.fault_addr);
            check({tag, "_fault_no_req2"},   {31'd0, sif.mem_req}, 32'd0);
        end else begin
            // Junk on st_* with valid held high must be ignored while busy.
            sif.st_valid = 1'b1;
            req_cycles = 0;
            check({tag, "_busy"}, {31'd0, sif.st_ready}, 32'd0);
            for (int i = 0; i <= v.gnt_dly; i++) begin
                if (sif.mem_req) req_cycles++;
                check({tag, "_mem_addr"},  sif.mem_addr, e.addr);
                check({tag, "_mem_wdata"}, sif.mem_wdata, e.wdata);
                check({tag, "_mem_be"},    {28'd0, sif.mem_be}, {28'd0, e.be});
                check({tag, "_no_early_done"}, {31'd0, sif.st_done}, 32'd0);
                if (i == v.gnt_dly) sif.mem_gnt = 1'b1;
                @(posedge clk); #1;
                sif.st_addr  = $urandom;
                sif.st_wdata = $urandom;
            end
            sif.mem_gnt  = 1'b0;
            sif.st_valid = 1'b0;
            check({tag, "_st_done"},    {31'd0, sif.st_done}, 32'd1);
            check({tag, "_req_drop"},   {31'd0, sif.mem_req}, 32'd0);
            check({tag, "_ready_back"}, {31'd0, sif.st_ready}, 32'd1);
            check({tag, "_req_cycles"}, req_cycles, v.gnt_dly + 1);
            @(posedge clk); #1;
            check({tag, "_done_once"},  {31'd0, sif.st_done}, 32'd0);
            last_addr  = e.addr;
            last_wdata = e.wdata;
            last_be    = e.be;
        end
    endtask

    initial begin
        vec_t v;
        checks       = 0;
        errors       = 0;
        last_addr    = '0;
        last_wdata   = '0;
        last_be      = '0;
        rst          = 1'b1;
        sif.st_valid = 1'b0;
        sif.st_addr  = '0;
        sif.st_wdata = '0;
        sif.st_op    = MEM_WORD;
        sif.mem_gnt  = 1'b0;

        vecs[0]  = '{MEM_BYTE,   32'h0000_1003, 32'hAABB_CCDD, 0, 1'b0, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000};
        vecs[1]  = '{MEM_HALF,   32'h0000_2002, 32'h0000_1234, 3, 1'b0, 32'h0000_2000, 32'h1234_1234, 4'b1100};
        vecs[2]  = '{MEM_WORD,   32'h0000_3001, 32'h1111_1111, 0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[3]  = '{MEM_HALF,   32'h0000_3003, 32'h2222_2222, 0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[4]  = '{MEM_BYTE_U, 32'h0000_4000, 32'h3333_3333, 0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[5]  = '{MEM_BYTE,   32'h0000_5000, 32'h0000_00A5, 1, 1'b0, 32'h0000_5000, 32'hA5A5_A5A5, 4'b0001};
        vecs[6]  = '{MEM_BYTE,   32'h0000_5001, 32'hFFFF_FF12, 0, 1'b0, 32'h0000_5000, 32'h1212_1212, 4'b0010};
        vecs[7]  = '{MEM_HALF,   32'h0000_6000, 32'hFFFF_8765, 2, 1'b0, 32'h0000_6000, 32'h8765_8765, 4'b0011};
        vecs[8]  = '{MEM_WORD,   32'h0000_7000, 32'hDEAD_BEEF, 0, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF, 4'b1111};
        vecs[9]  = '{MEM_HALF_U, 32'h0000_8000, 32'h4444_4444, 0, 1'b1, 32'h0, 32'h0, 4'b0000};
        vecs[10] = '{MEM_BYTE,   32'h0000_9002, 32'h0000_0034, 0, 1'b0, 32'h0000_9000, 32'h3434_3434, 4'b0100};

        // Reset values must appear before any clock edge.
        #2;
        check("rst_ready",      {31'd0, sif.st_ready}, 32'd1);
        check("rst_mem_req",    {31'd0, sif.mem_req}, 32'd0);
        check("rst_mem_be",     {28'd0, sif.mem_be}, 32'd0);
        check("rst_mem_addr",   sif.mem_addr, 32'd0);
        check("rst_mem_wdata",  sif.mem_wdata, 32'd0);
        check("rst_done",       {31'd0, sif.st_done}, 32'd0);
        check("rst_fault",      {31'd0, sif.st_fault}, 32'd0);
        check("rst_fault_addr", sif.st_fault_addr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_store(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back words with grant tied high.
        sif.mem_gnt  = 1'b1;
        sif.st_valid = 1'b1;
        sif.st_op    = MEM_WORD;
        sif.st_addr  = 32'h0000_A000;
        sif.st_wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        check("b2b_a_busy",  {31'd0, sif.st_ready}, 32'd0);
        check("b2b_a_addr",  sif.mem_addr, 32'h0000_A000);
        check("b2b_a_wdata", sif.mem_wdata, 32'hCAFE_0001);
        sif.st_addr  = 32'h0000_A004;
        sif.st_wdata = 32'hCAFE_0002;
        @(posedge clk); #1;
        check("b2b_a_done",  {31'd0, sif.st_done}, 32'd1);
        check("b2b_a_ready", {31'd0, sif.st_ready}, 32'd1);
        @(posedge clk); #1;
        sif.st_valid = 1'b0;
        check("b2b_b_busy",  {31'd0, sif.st_ready}, 32'd0);
        check("b2b_b_addr",  sif.mem_addr, 32'h0000_A004);
        check("b2b_b_wdata", sif.mem_wdata, 32'hCAFE_0002);
        check("b2b_b_nodone", {31'd0, sif.st_done}, 32'd0);
        @(posedge clk); #1;
        check("b2b_b_done",  {31'd0, sif.st_done}, 32'd1);
        check("b2b_b_ready", {31'd0, sif.st_ready}, 32'd1);
        @(posedge clk); #1;
        check("idle_gnt_ignored_req", {31'd0, sif.mem_req}, 32'd0);
        @(posedge clk); #1;
        check("idle_gnt_ignored_done", {31'd0, sif.st_done}, 32'd0);
        sif.mem_gnt = 1'b0;

        // Reset while a store waits for grant.
        sif.st_valid = 1'b1;
        sif.st_op    = MEM_BYTE;
        sif.st_addr  = 32'h0000_B001;
        sif.st_wdata = 32'h0000_0077;
        @(posedge clk); #1;
        sif.st_valid = 1'b0;
        check("mid_rst_pre_req", {31'd0, sif.mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req",   {31'd0, sif.mem_req}, 32'd0);
        check("mid_rst_ready", {31'd0, sif.st_ready}, 32'd1);
        check("mid_rst_be",    {28'd0, sif.mem_be}, 32'd0);
        sif.mem_gnt = 1'b1;
        @(posedge clk); #1;
        sif.mem_gnt = 1'b0;
        check("mid_rst_no_done", {31'd0, sif.st_done}, 32'd0);
        rst = 1'b0;
        last_addr  = '0;
        last_wdata = '0;
        last_be    = '0;
        check("post_rst_no_done", {31'd0, sif.st_done}, 32'd0);
        v = '{MEM_BYTE, 32'h0000_C002, 32'h0000_0055, 0, 1'b0, 32'h0000_C000, 32'h5555_5555, 4'b0100};
        do_store(v, "post_rst_sb");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
